// File: rtl/ps2_receiver_pkg.sv
// Shared keyboard definitions: PS/2 byte codes, frame length and receiver state encoding.
package ps2_receiver_pkg;

   localparam logic [7:0] PS2_BAT_OK     = 8'hAA;
   localparam logic [7:0] PS2_RESET_CMD  = 8'hFF;
   localparam int         PS2_FRAME_BITS = 11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

   // Odd parity holds when data plus parity bit carry an odd number of ones.
   function automatic logic ps2_parity_ok(input logic [7:0] data, input logic parity);
      return ^{data, parity};
   endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer, saturating glitch filter and falling-edge detect for the raw PS/2 clock.
module ps2_sync_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_raw,
   output logic o_fall
);

   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

   logic          r_meta;
   logic          r_sync;
   logic          r_filt;
   logic [CW-1:0] r_cnt;
   logic          r_fall;

   // Bring the asynchronous line into the clk domain; idle level is high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_raw;
         r_sync <= r_meta;
      end
   end

   // Accept a new level only after FILTER_LEN consecutive samples at it; flag 1->0 as a fall.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_filt <= 1'b1;
         r_cnt  <= '0;
         r_fall <= 1'b0;
      end else begin
         r_fall <= 1'b0;
         if (r_sync != r_filt) begin
            if (r_cnt == CNT_LAST) begin
               r_filt <= r_sync;
               r_cnt  <= '0;
               r_fall <= r_filt;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_fall = r_fall;

endmodule

// File: rtl/ps2_receiver.sv
// Device-to-host PS/2 frame receiver: deframes 11-bit frames, checks parity/framing,
// and flags the BAT-complete code so the reset sequencer can start.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for a start bit on a filtered fall
// ST_DATA   | shifting in D0..D7, LSB first
// ST_PARITY | capturing the parity bit
// ST_STOP   | checking stop bit and parity, publishing byte
module ps2_receiver
   import ps2_receiver_pkg::*;
#(
   parameter int FILTER_LEN    = 8,
   parameter int TIMEOUT_COUNT = 100000,
   parameter int TIMEOUT_WIDTH = 17
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       inhibit,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       parity_error,
   output logic       frame_error,
   output logic       reset_required,
   output logic       busy
);

   localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_COUNT - 1);

   logic                     w_fall;
   logic                     r_data_meta;
   logic                     r_data_sync;
   ps2_state_e               r_state;
   logic [2:0]               r_bit_cnt;
   logic [7:0]               r_shift;
   logic                     r_parity;
   logic [TIMEOUT_WIDTH-1:0] r_tmo;
   logic [7:0]               r_rx_data;
   logic                     r_rx_valid;
   logic                     r_parity_error;
   logic                     r_frame_error;
   logic                     r_reset_required;

   ps2_sync_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_clk_filter (
      .clk     (clk),
      .reset_n (reset_n),
      .i_raw   (ps2_clk),
      .o_fall  (w_fall)
   );

   // Data needs only synchronizing; it is stable around the clock fall that samples it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data_meta <= 1'b1;
         r_data_sync <= 1'b1;
      end else begin
         r_data_meta <= ps2_data;
         r_data_sync <= r_data_meta;
      end
   end

   // Frame FSM with timeout; inhibit beats a fall, a fall beats the timeout.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state          <= ST_IDLE;
         r_bit_cnt        <= '0;
         r_shift          <= '0;
         r_parity         <= 1'b0;
         r_tmo            <= '0;
         r_rx_data        <= '0;
         r_rx_valid       <= 1'b0;
         r_parity_error   <= 1'b0;
         r_frame_error    <= 1'b0;
         r_reset_required <= 1'b0;
      end else begin
         r_rx_valid       <= 1'b0;
         r_parity_error   <= 1'b0;
         r_frame_error    <= 1'b0;
         r_reset_required <= 1'b0;
         if (inhibit) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_tmo     <= '0;
         end else if (w_fall) begin
            r_tmo <= '0;
            case (r_state)
               ST_IDLE: begin
                  if (!r_data_sync) begin
                     r_state   <= ST_DATA;
                     r_bit_cnt <= '0;
                  end else begin
                     r_frame_error <= 1'b1;
                  end
               end
               ST_DATA: begin
                  r_shift <= {r_data_sync, r_shift[7:1]};
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= ST_PARITY;
                  end
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
               ST_PARITY: begin
                  r_parity <= r_data_sync;
                  r_state  <= ST_STOP;
               end
               ST_STOP: begin
                  r_state   <= ST_IDLE;
                  r_bit_cnt <= '0;
                  if (!r_data_sync) begin
                     r_frame_error <= 1'b1;
                  end else if (!ps2_parity_ok(r_shift, r_parity)) begin
                     r_parity_error <= 1'b1;
                  end else begin
                     r_rx_data        <= r_shift;
                     r_rx_valid       <= 1'b1;
                     r_reset_required <= (r_shift == PS2_BAT_OK);
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end else if (r_state != ST_IDLE) begin
            if (r_tmo == TMO_LAST) begin
               r_frame_error <= 1'b1;
               r_state       <= ST_IDLE;
               r_bit_cnt     <= '0;
               r_tmo         <= '0;
            end else begin
               r_tmo <= r_tmo + 1'b1;
            end
         end
      end
   end

   assign rx_data        = r_rx_data;
   assign rx_valid       = r_rx_valid;
   assign parity_error   = r_parity_error;
   assign frame_error    = r_frame_error;
   assign reset_required = r_reset_required;
   assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver with a scaled-down PS/2 clock and timeout.
module tb_ps2_receiver;

   localparam int HALF = 40;
   localparam int TMO  = 1000;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       inhibit = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       parity_error;
   logic       frame_error;
   logic       reset_required;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int n_valid = 0, n_perr = 0, n_ferr = 0, n_rr = 0, n_rr_alone = 0, n_multi = 0;
   int b_valid, b_perr, b_ferr, b_rr;

   ps2_receiver #(
      .FILTER_LEN    (8),
      .TIMEOUT_COUNT (TMO),
      .TIMEOUT_WIDTH (10)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .ps2_clk        (ps2_clk),
      .ps2_data       (ps2_data),
      .inhibit        (inhibit),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .parity_error   (parity_error),
      .frame_error    (frame_error),
      .reset_required (reset_required),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   // Pulse tally, sampled away from the active edge.
   always @(negedge clk) begin
      if (rx_valid === 1'b1) n_valid++;
      if (parity_error === 1'b1) n_perr++;
      if (frame_error === 1'b1) n_ferr++;
      if (reset_required === 1'b1) n_rr++;
      if (reset_required === 1'b1 && rx_valid !== 1'b1) n_rr_alone++;
      if (int'(rx_valid) + int'(parity_error) + int'(frame_error) > 1) n_multi++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic snap();
      b_valid = n_valid;
      b_perr  = n_perr;
      b_ferr  = n_ferr;
      b_rr    = n_rr;
   endtask

   task automatic chk_counts(input string tag, input int v, input int p, input int f, input int r);
      chk({tag, "_valid"}, n_valid - b_valid, v);
      chk({tag, "_perr"},  n_perr - b_perr,   p);
      chk({tag, "_ferr"},  n_ferr - b_ferr,   f);
      chk({tag, "_rr"},    n_rr - b_rr,       r);
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      wait_clk(HALF);
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(p);
      send_bit(s);
      ps2_data = 1'b1;
   endtask

   initial begin
      // Reset values while reset_n is low
      wait_clk(3);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_perr", parity_error, 1'b0);
      chk("rst_ferr", frame_error, 1'b0);
      chk("rst_rr", reset_required, 1'b0);
      chk("rst_busy", busy, 1'b0);
      snap();
      reset_n = 1'b1;
      wait_clk(30);
      chk_counts("release", 0, 0, 0, 0);

      // Good frame 0x1C
      snap();
      send_frame(8'h1C, 1'b0, 1'b1);
      wait_clk(40);
      chk_counts("f1C", 1, 0, 0, 0);
      chk("f1C_data", rx_data, 8'h1C);
      chk("f1C_busy", busy, 1'b0);

      // BAT code 0xAA
      snap();
      send_frame(8'hAA, 1'b1, 1'b1);
      wait_clk(40);
      chk_counts("fAA", 1, 0, 0, 1);
      chk("fAA_data", rx_data, 8'hAA);
      chk("fAA_rr_coincident", n_rr_alone, 0);

      // Parity error keeps previous byte
      snap();
      send_frame(8'h1C, 1'b1, 1'b1);
      wait_clk(40);
      chk_counts("par", 0, 1, 0, 0);
      chk("par_data", rx_data, 8'hAA);

      // Bad stop bit then back-to-back good frame
      snap();
      send_frame(8'h5A, 1'b1, 1'b0);
      send_frame(8'h5A, 1'b1, 1'b1);
      wait_clk(40);
      chk_counts("b2b", 1, 0, 1, 0);
      chk("b2b_data", rx_data, 8'h5A);

      // Timeout after 5 bits
      snap();
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      ps2_data = 1'b1;
      wait_clk(900);
      chk("tmo_busy_early", busy, 1'b1);
      chk("tmo_ferr_early", n_ferr - b_ferr, 0);
      wait_clk(TMO + 10 - 900);
      chk("tmo_ferr", n_ferr - b_ferr, 1);
      chk("tmo_busy", busy, 1'b0);
      snap();
      send_frame(8'h29, 1'b0, 1'b1);
      wait_clk(40);
      chk_counts("f29", 1, 0, 0, 0);
      chk("f29_data", rx_data, 8'h29);

      // 3-cycle glitches with data high and low
      snap();
      for (int i = 0; i < 10; i++) begin
         ps2_data = (i < 5);
         ps2_clk = 1'b0;
         wait_clk(3);
         ps2_clk = 1'b1;
         wait_clk(20);
      end
      ps2_data = 1'b1;
      wait_clk(20);
      chk_counts("glitch", 0, 0, 0, 0);
      chk("glitch_busy", busy, 1'b0);

      // Inhibit mid-frame, host pulls the clock low
      snap();
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      chk("inh_busy_before", busy, 1'b1);
      inhibit = 1'b1;
      wait_clk(3);
      chk("inh_busy", busy, 1'b0);
      ps2_clk = 1'b0;
      ps2_data = 1'b1;
      wait_clk(200);
      ps2_clk = 1'b1;
      wait_clk(30);
      inhibit = 1'b0;
      wait_clk(20);
      chk_counts("inh", 0, 0, 0, 0);
      chk("inh_busy_after", busy, 1'b0);

      // Reset mid-frame
      snap();
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      reset_n = 1'b0;
      ps2_data = 1'b1;
      wait_clk(2);
      chk("mrst_data", rx_data, 8'h00);
      chk("mrst_busy", busy, 1'b0);
      wait_clk(20);
      reset_n = 1'b1;
      wait_clk(200);
      chk_counts("mrst", 0, 0, 0, 0);
      chk("mrst_busy_after", busy, 1'b0);
      chk("mrst_data_after", rx_data, 8'h00);

      // Recovery frame
      snap();
      send_frame(8'h1C, 1'b0, 1'b1);
      wait_clk(40);
      chk_counts("rec", 1, 0, 0, 0);
      chk("rec_data", rx_data, 8'h1C);
      chk("one_pulse_per_cycle", n_multi, 0);
      chk("rr_only_with_valid", n_rr_alone, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
